// File: rtl/uart_cfg_sequencer.sv
// APB master that atomically reprograms the UART SE/BR registers once the line is quiet:
// SE with enable cleared, then BR, then SE with its final value.
module uart_cfg_sequencer #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,  // 32-byte aligned
  parameter int          TIMEOUT   = 64              // 2..255
) (
  input  logic        pclk,
  input  logic        preset,
  input  logic        cfg_start,
  input  logic [2:0]  cfg_se,
  input  logic [7:0]  cfg_br,
  input  logic        uart_busy,
  output logic        cfg_busy,
  output logic        cfg_done,
  output logic [1:0]  cfg_err,
  output logic [1:0]  cfg_err_step,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] paddr,
  output logic [31:0] pwdata,
  output logic [3:0]  pstrb,
  input  logic        pready,
  input  logic        pslverr
);

  typedef enum logic [2:0] {IDLE, WAIT_QUIET, SETUP, ACCESS, DONE} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_SLV  = 2'b01;
  localparam logic [1:0] ERR_TMO  = 2'b10;

  state_t      state;
  logic [1:0]  step;
  logic [7:0]  timer;
  logic [2:0]  se_q;
  logic [7:0]  br_q;
  logic [1:0]  step_nxt;

  assign step_nxt = step + 2'd1;

  function automatic logic [31:0] step_addr(input logic [1:0] s);
    return BASE_ADDR + ((s == 2'd1) ? 32'h8 : 32'h4);
  endfunction

  // Step 0 writes SE with the enable bit forced low so BR changes on a disabled UART.
  function automatic logic [31:0] step_wdata(input logic [1:0] s, input logic [2:0] se,
                                             input logic [7:0] br);
    case (s)
      2'd0:    return {29'b0, se[2:1], 1'b0};
      2'd1:    return {24'b0, br};
      default: return {29'b0, se};
    endcase
  endfunction

  always_ff @(posedge pclk) begin
    if (preset) begin
      state        <= IDLE;
      step         <= 2'd0;
      timer        <= 8'd0;
      se_q         <= 3'd0;
      br_q         <= 8'd0;
      cfg_busy     <= 1'b0;
      cfg_done     <= 1'b0;
      cfg_err      <= ERR_OK;
      cfg_err_step <= 2'd0;
      psel         <= 1'b0;
      penable      <= 1'b0;
      pwrite       <= 1'b0;
      paddr        <= 32'd0;
      pwdata       <= 32'd0;
      pstrb        <= 4'd0;
    end else begin
      cfg_done <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_start) begin
            se_q         <= cfg_se;
            br_q         <= cfg_br;
            cfg_err      <= ERR_OK;
            cfg_err_step <= 2'd0;
            step         <= 2'd0;
            cfg_busy     <= 1'b1;
            state        <= WAIT_QUIET;
          end
        end
        WAIT_QUIET: begin
          if (!uart_busy) begin
            psel    <= 1'b1;
            penable <= 1'b0;
            pwrite  <= 1'b1;
            pstrb   <= 4'hF;
            paddr   <= step_addr(step);
            pwdata  <= step_wdata(step, se_q, br_q);
            timer   <= 8'd0;
            state   <= SETUP;
          end
        end
        SETUP: begin
          penable <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          // pready wins over an expiring timer in the same cycle
          if (pready) begin
            if (pslverr || step == 2'd2) begin
              if (pslverr) begin
                cfg_err      <= ERR_SLV;
                cfg_err_step <= step;
              end
              psel     <= 1'b0;
              penable  <= 1'b0;
              pwrite   <= 1'b0;
              pstrb    <= 4'd0;
              paddr    <= 32'd0;
              pwdata   <= 32'd0;
              cfg_done <= 1'b1;
              state    <= DONE;
            end else begin
              step    <= step_nxt;
              penable <= 1'b0;
              paddr   <= step_addr(step_nxt);
              pwdata  <= step_wdata(step_nxt, se_q, br_q);
              timer   <= 8'd0;
              state   <= SETUP;
            end
          end else if (timer == TMO_LAST) begin
            cfg_err      <= ERR_TMO;
            cfg_err_step <= step;
            psel         <= 1'b0;
            penable      <= 1'b0;
            pwrite       <= 1'b0;
            pstrb        <= 4'd0;
            paddr        <= 32'd0;
            pwdata       <= 32'd0;
            cfg_done     <= 1'b1;
            state        <= DONE;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        DONE: begin
          cfg_busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          cfg_busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
